hamming_enc_stream: RTL

- Streaming Hamming(IP_BIT+4, IP_BIT) single-error-correcting encoder.
- It is the transmit-side counterpart of the lab's Hamming decoder IP. It produces codewords in exactly the bit layout that decoder consumes.
- Input side uses a valid/ready handshake. Codewords are buffered in a 2-entry output FIFO with backpressure.
- A running count of accepted words is exported for bench and debug.

---
 rtl/hamming_enc_stream.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(IP_BIT+4, IP_BIT) SEC encoder feeding a 2-entry codeword FIFO; word counter for debug.
// Latency: 1 cycle from accept edge to out_valid when the FIFO is empty.
// Backpressure: in_ready = FIFO not full (registered count), independent of same-cycle out_ready.
// Optional build macro HAMMING_ERR_INJ_EN: single-bit error injection into the stored codeword.

// Generic synchronous FIFO with valid/ready on both sides; storage has no reset (data path only).
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign push_rdy = (count < FULL_CNT);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[head];
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST_PTR) ? '0 : head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write on push; contents are only observed when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_dat;
        end
    end
endmodule

module hamming_enc_stream #(
    parameter int IP_BIT = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IP_BIT-1:0]   in_data,
    input  logic                inj_en,
    input  logic [3:0]          inj_pos,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IP_BIT+3:0]   out_code,
    output logic [CNT_W-1:0]    word_cnt
);
    localparam int NW = IP_BIT + 4;
    localparam logic [NW-1:0] ONE = {{(NW-1){1'b0}}, 1'b1};

    // Index of the data bit that lands on codeword position pos (non-power-of-two positions only).
    function automatic int data_index(input int pos);
        int n;
        n = 0;
        for (int i = 3; i < pos; i++) begin
            if ((i & (i - 1)) != 0) begin
                n++;
            end
        end
        return n;
    endfunction

    // Data positions covered by parity bit p, in out_code bit order (position 1 is the MSB).
    function automatic logic [NW-1:0] parity_mask(input int p);
        logic [NW-1:0] m;
        m = '0;
        for (int i = 1; i <= NW; i++) begin
            if (((i & p) != 0) && ((i & (i - 1)) != 0)) begin
                m = m | (ONE << (NW - i));
            end
        end
        return m;
    endfunction

    localparam logic [NW-1:0] MASK_P1 = parity_mask(1);
    localparam logic [NW-1:0] MASK_P2 = parity_mask(2);
    localparam logic [NW-1:0] MASK_P4 = parity_mask(4);
    localparam logic [NW-1:0] MASK_P8 = parity_mask(8);

    logic [NW-1:0] data_only;
    logic          p1;
    logic          p2;
    logic          p4;
    logic          p8;
    logic [7:0]    parity_bits;
    logic [NW-1:0] code_clean;
    logic [NW-1:0] code_word;
    logic [NW-1:0] fifo_dat;
    logic [NW-1:0] hold_code;
    logic          fifo_vld;
    logic          accept;
    logic          pop;

    // Scatter data bits onto the non-parity positions; d0 is the MSB of in_data.
    for (genvar pos = 1; pos <= NW; pos++) begin : g_pos
        if ((pos & (pos - 1)) != 0) begin : g_data
            assign data_only[NW-pos] = in_data[IP_BIT-1-data_index(pos)];
        end else begin : g_par
            assign data_only[NW-pos] = 1'b0;
        end
    end

    // Even parity over the covered data positions.
    assign p1 = ^(data_only & MASK_P1);
    assign p2 = ^(data_only & MASK_P2);
    assign p4 = ^(data_only & MASK_P4);
    assign p8 = ^(data_only & MASK_P8);

    // Positions 1..8 as an 8-bit slice, then shifted up to the top of the codeword.
    assign parity_bits = {p1, p2, 1'b0, p4, 3'b000, p8};
    assign code_clean  = data_only | (NW'(parity_bits) << (NW - 8));

`ifdef HAMMING_ERR_INJ_EN
    logic [NW-1:0] inj_mask;

    // One-hot flip mask; out-of-range positions (0 or beyond the codeword) inject nothing.
    always_comb begin
        inj_mask = '0;
        if (inj_en && (inj_pos != 4'd0) && ({1'b0, inj_pos} <= 5'(NW))) begin
            inj_mask = ONE << (NW - int'(inj_pos));
        end
    end

    assign code_word = code_clean ^ inj_mask;
`else
    logic unused_inj;

    assign unused_inj = ^{inj_en, inj_pos};
    assign code_word  = code_clean;
`endif

    fifo #(
        .W     (NW),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (code_word),
        .pop_vld  (fifo_vld),
        .pop_rdy  (out_ready),
        .pop_dat  (fifo_dat)
    );

    assign accept    = in_valid && in_ready;
    assign pop       = fifo_vld && out_ready;
    assign out_valid = fifo_vld;
    assign out_code  = fifo_vld ? fifo_dat : hold_code;

    // Keep the last delivered codeword on the output while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_code <= '0;
        end else if (pop) begin
            hold_code <= fifo_dat;
        end
    end

    // Accepted-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end
endmodule
